// File: rtl/perip_cfg_pkg.sv
// perip_cfg_pkg: register indices, bank size and local access FSM states
package perip_cfg_pkg;
  localparam int REG_NUM = 5;
  localparam logic [2:0] IDX_LED_FREQ = 3'd0;
  localparam logic [2:0] IDX_BZ_FREQ = 3'd1;
  localparam logic [2:0] IDX_LEDR = 3'd2;
  localparam logic [2:0] IDX_LEDG = 3'd3;
  localparam logic [2:0] IDX_LEDB = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} loc_state_e;
endpackage

// File: rtl/perip_cfg_arbiter_regfile.sv
// cfg_regfile: five 32-bit config registers, one write port, two async read ports
module cfg_regfile
  import perip_cfg_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [31:0]                 wdata_i,
  input  logic [AW-1:0]               raddr_a_i,
  input  logic [AW-1:0]               raddr_b_i,
  output logic [31:0]                 rdata_a_o,
  output logic [31:0]                 rdata_b_o,
  output logic [REG_NUM-1:0][31:0]    regs_o
);
  localparam logic [AW-1:0] LAST = AW'(REG_NUM - 1);
  logic [REG_NUM-1:0][31:0] regs_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else if (we_i && waddr_i <= LAST) regs_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o = raddr_a_i <= LAST ? regs_q[raddr_a_i] : '0;
  assign rdata_b_o = raddr_b_i <= LAST ? regs_q[raddr_b_i] : '0;
  assign regs_o = regs_q;
endmodule

// File: rtl/perip_cfg_arbiter.sv
// perip_cfg_arbiter: host-priority arbitration of the peripheral config bank
module perip_cfg_arbiter
  import perip_cfg_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h60000000,
  parameter int          LOC_AW  = 3
) (
  input  logic              FB_CLK,
  input  logic              RST_n,
  input  logic              HOST_ALE,
  input  logic              HOST_CS,
  input  logic [31:0]       HOST_ADDR,
  input  logic              HOST_WE,
  input  logic [31:0]       HOST_WDATA,
  output logic [31:0]       HOST_RDATA,
  input  logic              LOC_REQ,
  input  logic              LOC_WE,
  input  logic [LOC_AW-1:0] LOC_ADDR,
  input  logic [31:0]       LOC_WDATA,
  output logic              LOC_GNT,
  output logic              LOC_DONE,
  output logic              LOC_ERR,
  output logic [31:0]       LOC_RDATA,
  output logic [15:0]       LOC_STALL_CNT,
  output logic [31:0]       LED_FREQ_Qout,
  output logic [31:0]       BZ_FREQ_Qout,
  output logic [31:0]       LEDR_Puty_Qout,
  output logic [31:0]       LEDG_Puty_Qout,
  output logic [31:0]       LEDB_Puty_Qout
);
  localparam logic [LOC_AW-1:0] LAST = LOC_AW'(REG_NUM - 1);
  loc_state_e state_q, state_d;
  logic host_hit, host_dp_q, blocked, gnt, rf_we, unused_ok;
  logic [LOC_AW-1:0] host_idx, host_idx_q, loc_idx_q, rf_waddr;
  logic [31:0] host_rdata_q, loc_rdata_q, loc_wdata_q, rf_wdata, rdata_a, rdata_b;
  logic loc_we_q, loc_err_q;
  logic [15:0] stall_q;
  logic [REG_NUM-1:0][31:0] regs;
  assign unused_ok = ^HOST_ADDR[1:0];
  assign host_hit = HOST_ALE & HOST_CS & (HOST_ADDR[31:5] == FB_BASE[31:5]);
  assign host_idx = LOC_AW'(HOST_ADDR[4:2]);
  assign blocked = host_hit | host_dp_q;
  assign gnt = (state_q == S_WAIT) & !blocked;
  // Host data phase and local grant are mutually exclusive, so one write port suffices
  assign rf_we = (host_dp_q & HOST_WE) | (gnt & loc_we_q);
  assign rf_waddr = host_dp_q ? host_idx_q : loc_idx_q;
  assign rf_wdata = host_dp_q ? HOST_WDATA : loc_wdata_q;
  cfg_regfile #(.AW(LOC_AW)) u_regfile (
    .clk       (FB_CLK),
    .rst_n     (RST_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (host_idx),
    .raddr_b_i (loc_idx_q),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .regs_o    (regs)
  );
  always_comb begin
    state_d = state_q == S_IDLE ? (LOC_REQ ? S_WAIT : S_IDLE)
            : state_q == S_WAIT ? (gnt ? S_DONE : S_WAIT)
            : S_IDLE;
  end
  always_ff @(posedge FB_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= S_IDLE;
      host_dp_q    <= 1'b0;
      host_idx_q   <= '0;
      host_rdata_q <= '0;
      loc_we_q     <= 1'b0;
      loc_idx_q    <= '0;
      loc_wdata_q  <= '0;
      loc_rdata_q  <= '0;
      loc_err_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q   <= state_d;
      host_dp_q <= host_hit;
      if (host_hit) begin
        host_idx_q   <= host_idx;
        host_rdata_q <= rdata_a;
      end
      if (state_q == S_IDLE && LOC_REQ) begin
        loc_we_q    <= LOC_WE;
        loc_idx_q   <= LOC_ADDR;
        loc_wdata_q <= LOC_WDATA;
      end
      if (gnt) begin
        loc_rdata_q <= rdata_b;
        loc_err_q   <= loc_idx_q > LAST;
      end
      if (state_q == S_WAIT && !gnt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign HOST_RDATA     = host_rdata_q;
  assign LOC_GNT        = gnt;
  assign LOC_DONE       = state_q == S_DONE;
  assign LOC_ERR        = LOC_DONE & loc_err_q;
  assign LOC_RDATA      = loc_rdata_q;
  assign LOC_STALL_CNT  = stall_q;
  assign LED_FREQ_Qout  = regs[IDX_LED_FREQ];
  assign BZ_FREQ_Qout   = regs[IDX_BZ_FREQ];
  assign LEDR_Puty_Qout = regs[IDX_LEDR];
  assign LEDG_Puty_Qout = regs[IDX_LEDG];
  assign LEDB_Puty_Qout = regs[IDX_LEDB];
endmodule
